// File: rtl/exec_pkg.sv
// Shared definitions for the two-stage execute pipeline: op codes, flag bit
// positions and default datapath sizing.
package exec_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 32;

  typedef enum logic [3:0] {
    OP_ADD    = 4'd0,
    OP_SUB    = 4'd1,
    OP_AND    = 4'd2,
    OP_OR     = 4'd3,
    OP_XOR    = 4'd4,
    OP_SLL    = 4'd5,
    OP_SRL    = 4'd6,
    OP_SRA    = 4'd7,
    OP_SLT    = 4'd8,
    OP_SLTU   = 4'd9,
    OP_PASS_B = 4'd10
  } op_e;

  // Flags travel as {negative, zero, carry, overflow}.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/exec_if.sv
// Instruction-in / result-out handshake bundle of the execute pipeline.
// master = instruction source and result sink, slave = the pipeline.
interface exec_if #(
   parameter int WIDTH = exec_pkg::DEFAULT_WIDTH,
   parameter int AW    = $clog2(exec_pkg::DEFAULT_DEPTH)
);

   logic             in_valid;
   logic             in_ready;
   logic [3:0]       in_op;
   logic [AW-1:0]    in_rs1;
   logic [AW-1:0]    in_rs2;
   logic [AW-1:0]    in_rd;
   logic [WIDTH-1:0] in_imm;
   logic             in_use_imm;
   logic             in_wr_en;

   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic [AW-1:0]    out_rd;
   logic [3:0]       out_flags;

   modport master (
      output in_valid, in_op, in_rs1, in_rs2, in_rd, in_imm, in_use_imm, in_wr_en,
      input  in_ready,
      input  out_valid, out_result, out_rd, out_flags,
      output out_ready
   );

   modport slave (
      input  in_valid, in_op, in_rs1, in_rs2, in_rd, in_imm, in_use_imm, in_wr_en,
      output in_ready,
      output out_valid, out_result, out_rd, out_flags,
      input  out_ready
   );

endinterface

// File: rtl/exec_alu.sv
// Combinational ALU: (a, b, op) -> (result, {N,Z,C,V}). Undefined op codes
// produce a zero result with every flag clear.
module exec_alu
   import exec_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags
);

   localparam int SW = $clog2(WIDTH);

   logic [WIDTH:0]  sum;
   logic [WIDTH:0]  diff;
   logic [SW-1:0]   shamt;
   logic            op_known;

   always_comb begin
      // NOTE: every output of this block is given a value before the case so no path can infer a latch.
      result   = '0;
      flags    = '0;
      op_known = 1'b1;
      sum      = {1'b0, a} + {1'b0, b};
      diff     = {1'b0, a} - {1'b0, b};
      shamt    = b[SW-1:0];
      case (op)
         OP_ADD: begin
            result        = sum[WIDTH-1:0];
            flags[FLAG_C] = sum[WIDTH];
            flags[FLAG_V] = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            // Carry means "no borrow", i.e. a >= b unsigned.
            result        = diff[WIDTH-1:0];
            flags[FLAG_C] = ~diff[WIDTH];
            flags[FLAG_V] = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND:    result = a & b;
         OP_OR:     result = a | b;
         OP_XOR:    result = a ^ b;
         OP_SLL:    result = a << shamt;
         OP_SRL:    result = a >> shamt;
         OP_SRA:    result = $signed(a) >>> shamt;
         OP_SLT:    result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLTU:   result = {{(WIDTH-1){1'b0}}, (a < b)};
         OP_PASS_B: result = b;
         default:   op_known = 1'b0;
      endcase
      if (op_known) begin
         flags[FLAG_N] = result[WIDTH-1];
         flags[FLAG_Z] = (result == '0);
      end
   end

endmodule

// File: rtl/exec_pipe.sv
// Two-stage execute pipeline: S1 latches the instruction, S2 holds the ALU
// result until the sink takes it, retiring into a DEPTH x WIDTH register file.
module exec_pipe
   import exec_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input logic   clk,
   input logic   rst_n,
   exec_if.slave bus
);

   localparam int AW = $clog2(DEPTH);

   typedef struct packed {
      logic [3:0]       op;
      logic [AW-1:0]    rs1;
      logic [AW-1:0]    rs2;
      logic [AW-1:0]    rd;
      logic [WIDTH-1:0] imm;
      logic             use_imm;
      logic             wr_en;
   } s1_t;

   typedef struct packed {
      logic [WIDTH-1:0] result;
      logic [AW-1:0]    rd;
      logic [3:0]       flags;
      logic             wr_en;
   } s2_t;

   logic             s1_valid;
   logic             s2_valid;
   s1_t              s1;
   s2_t              s2;
   logic [WIDTH-1:0] regs [DEPTH];

   logic             accept;
   logic             advance;
   logic             retire;
   logic             s2_fwd;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] alu_result;
   logic [3:0]       alu_flags;

   assign advance      = s1_valid && (!s2_valid || bus.out_ready);
   assign accept       = bus.in_valid && bus.in_ready;
   assign retire       = s2_valid && bus.out_ready && s2.wr_en && (s2.rd != '0);
   assign s2_fwd       = s2_valid && s2.wr_en && (s2.rd != '0);

   assign bus.in_ready   = !s1_valid || advance;
   assign bus.out_valid  = s2_valid;
   assign bus.out_result = s2.result;
   assign bus.out_rd     = s2.rd;
   assign bus.out_flags  = s2.flags;

   // S2 only moves when it is retiring, so its result is forwarded ahead of the same-edge register write.
   always_comb begin
      op_a = '0;
      op_b = '0;
      if (s1.rs1 != '0) op_a = (s2_fwd && s2.rd == s1.rs1) ? s2.result : regs[s1.rs1];
      if (s1.use_imm)          op_b = s1.imm;
      else if (s1.rs2 != '0)   op_b = (s2_fwd && s2.rd == s1.rs2) ? s2.result : regs[s1.rs2];
   end

   exec_alu #(.WIDTH(WIDTH)) u_alu (
      .a      (op_a),
      .b      (op_b),
      .op     (s1.op),
      .result (alu_result),
      .flags  (alu_flags)
   );

   // NOTE: the register file sits in the async reset because cleared registers are part of the reset contract; this rules out mapping it to a RAM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else if (retire) begin
         regs[s2.rd] <= s2.result;
      end
   end

   // NOTE: state updates use non-blocking assignments so every stage samples the pre-edge value of its neighbour.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         s1       <= '0;
         s2       <= '0;
      end else begin
         if (accept) begin
            s1_valid <= 1'b1;
            s1       <= '{op: bus.in_op, rs1: bus.in_rs1, rs2: bus.in_rs2, rd: bus.in_rd,
                          imm: bus.in_imm, use_imm: bus.in_use_imm, wr_en: bus.in_wr_en};
         end else if (advance) begin
            s1_valid <= 1'b0;
         end
         if (advance) begin
            s2_valid <= 1'b1;
            s2       <= '{result: alu_result, rd: s1.rd, flags: alu_flags, wr_en: s1.wr_en};
         end else if (bus.out_ready) begin
            s2_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_exec_pipe.sv
// Bench for exec_pipe: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a sequential-execution model.
module tb_exec_pipe;
   import exec_pkg::*;

   localparam int WIDTH = 32;
   localparam int DEPTH = 32;
   localparam int AW    = 5;
   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   typedef struct {
      logic [31:0] result;
      logic [4:0]  rd;
      logic [3:0]  flags;
      int          acc;
   } pend_t;

   typedef struct {
      logic [31:0] result;
      logic [4:0]  rd;
      logic [3:0]  flags;
      int          cyc;
   } done_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;

   pend_t       pipe_q[$];
   done_t       log_q[$];
   logic [31:0] mregs [DEPTH];
   logic [31:0] edge_vals [5] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};

   exec_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

   exec_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   // Architectural meaning of each op, computed with wide integer arithmetic.
   function automatic void model_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] r, output logic [3:0] f);
      longint          sa = longint'($signed(a));
      longint          sb = longint'($signed(b));
      longint unsigned ua = 64'(a);
      longint unsigned ub = 64'(b);
      int              amt = int'(b & 32'd31);
      logic            c = 1'b0;
      logic            v = 1'b0;
      case (op)
         4'd0: begin
            r = 32'(ua + ub);
            c = (ua + ub) > 64'hFFFF_FFFF;
            v = (sa + sb) > SMAX || (sa + sb) < SMIN;
         end
         4'd1: begin
            r = 32'(ua - ub);
            c = ua >= ub;
            v = (sa - sb) > SMAX || (sa - sb) < SMIN;
         end
         4'd2:  r = a & b;
         4'd3:  r = a | b;
         4'd4:  r = a ^ b;
         4'd5:  r = a << amt;
         4'd6:  r = a >> amt;
         4'd7:  r = 32'(sa >>> amt);
         4'd8:  r = (sa < sb) ? 32'd1 : 32'd0;
         4'd9:  r = (ua < ub) ? 32'd1 : 32'd0;
         4'd10: r = b;
         default: r = 32'd0;
      endcase
      f = (op <= 4'd10) ? {r[31], (r == 32'd0), c, v} : 4'b0000;
   endfunction

   // Compare process: inputs are stable at the falling edge, so this is also
   // where the model decides what the next rising edge accepts and retires.
   always @(negedge clk) begin
      if (!rst_n) begin
         pipe_q.delete();
         for (int i = 0; i < DEPTH; i++) mregs[i] = 32'd0;
         check("rst_out_valid", 64'(bus.out_valid), 64'd0);
         check("rst_out_result", 64'(bus.out_result), 64'd0);
         check("rst_out_rd_flags", 64'({bus.out_rd, bus.out_flags}), 64'd0);
         check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      end else begin
         logic exp_ov;
         exp_ov = (pipe_q.size() > 0) && (cyc >= pipe_q[0].acc + 2);
         check("out_valid", 64'(bus.out_valid), 64'(exp_ov));
         check("in_ready", 64'(bus.in_ready), 64'((pipe_q.size() < 2) || bus.out_ready));
         if (bus.out_valid && pipe_q.size() > 0) begin
            check("out_result", 64'(bus.out_result), 64'(pipe_q[0].result));
            check("out_rd", 64'(bus.out_rd), 64'(pipe_q[0].rd));
            check("out_flags", 64'(bus.out_flags), 64'(pipe_q[0].flags));
            if (bus.out_ready) begin
               log_q.push_back('{result: bus.out_result, rd: bus.out_rd, flags: bus.out_flags, cyc: cyc});
               void'(pipe_q.pop_front());
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            logic [31:0] a, b, r;
            logic [3:0]  f;
            a = (bus.in_rs1 == 0) ? 32'd0 : mregs[bus.in_rs1];
            b = bus.in_use_imm ? bus.in_imm : ((bus.in_rs2 == 0) ? 32'd0 : mregs[bus.in_rs2]);
            model_alu(bus.in_op, a, b, r, f);
            if (bus.in_wr_en && bus.in_rd != 0) mregs[bus.in_rd] = r;
            pipe_q.push_back('{result: r, rd: bus.in_rd, flags: f, acc: cyc});
         end
      end
   end

   task automatic issue(input logic [3:0] op, input int rs1, input int rs2, input int rd,
                        input logic [31:0] imm, input logic use_imm, input logic wr_en, output int acc);
      bus.in_valid   = 1'b1;
      bus.in_op      = op;
      bus.in_rs1     = 5'(rs1);
      bus.in_rs2     = 5'(rs2);
      bus.in_rd      = 5'(rd);
      bus.in_imm     = imm;
      bus.in_use_imm = use_imm;
      bus.in_wr_en   = wr_en;
      acc = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            acc = cyc;
            break;
         end
      end
      if (acc < 0) check("issue_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      bit empty = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (pipe_q.size() == 0 && !bus.out_valid) begin
            empty = 1'b1;
            break;
         end
      end
      if (!empty) check("drain_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic check_log(input string name, input int idx, input logic [31:0] res, input logic [3:0] flg);
      if (idx < log_q.size()) begin
         check({name, "_result"}, 64'(log_q[idx].result), 64'(res));
         check({name, "_flags"}, 64'(log_q[idx].flags), 64'(flg));
      end else begin
         check({name, "_missing"}, 64'(log_q.size()), 64'(idx + 1));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, t1, n0, rel;
      rst_n          = 1'b0;
      bus.in_valid   = 1'b0;
      bus.in_op      = 4'd0;
      bus.in_rs1     = '0;
      bus.in_rs2     = '0;
      bus.in_rd      = '0;
      bus.in_imm     = '0;
      bus.in_use_imm = 1'b0;
      bus.in_wr_en   = 1'b0;
      bus.out_ready  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.out_ready = 1'b1;

      // Dependent pair with no bubble: 5 then 8, one cycle apart.
      n0 = log_q.size();
      issue(OP_ADD, 0, 0, 1, 32'd5, 1'b1, 1'b1, t0);
      issue(OP_ADD, 1, 0, 2, 32'd3, 1'b1, 1'b1, t1);
      drain();
      check_log("raw_first", n0, 32'd5, 4'b0000);
      check_log("raw_second", n0 + 1, 32'd8, 4'b0000);
      check("raw_accept_b2b", 64'(t1), 64'(t0 + 1));
      if (n0 + 1 < log_q.size()) begin
         check("raw_latency_first", 64'(log_q[n0].cyc), 64'(t0 + 2));
         check("raw_latency_second", 64'(log_q[n0 + 1].cyc), 64'(t0 + 3));
      end

      // Signed overflow on ADD.
      n0 = log_q.size();
      issue(OP_ADD, 0, 0, 4, 32'h7FFF_FFFF, 1'b1, 1'b1, t0);
      issue(OP_ADD, 4, 0, 5, 32'd1, 1'b1, 1'b1, t0);
      drain();
      check_log("add_ovf", n0 + 1, 32'h8000_0000, 4'b1001);

      // SUB: equal operands, then 0 - 1.
      n0 = log_q.size();
      issue(OP_SUB, 1, 1, 3, 32'd0, 1'b0, 1'b1, t0);
      issue(OP_SUB, 0, 0, 6, 32'd1, 1'b1, 1'b1, t0);
      drain();
      check_log("sub_zero", n0, 32'd0, 4'b0110);
      check_log("sub_borrow", n0 + 1, 32'hFFFF_FFFF, 4'b1000);

      // Writes to r0 are dropped.
      n0 = log_q.size();
      issue(OP_ADD, 0, 0, 0, 32'd9, 1'b1, 1'b1, t0);
      issue(OP_PASS_B, 0, 0, 9, 32'd0, 1'b0, 1'b1, t0);
      drain();
      check_log("r0_write", n0, 32'd9, 4'b0000);
      check_log("r0_read", n0 + 1, 32'd0, 4'b0100);

      // Sink stalls for three cycles with a third instruction waiting.
      n0 = log_q.size();
      bus.out_ready = 1'b0;
      issue(OP_ADD, 0, 0, 7, 32'd100, 1'b1, 1'b1, t0);
      issue(OP_ADD, 0, 0, 7, 32'd101, 1'b1, 1'b1, t0);
      bus.in_valid = 1'b1;
      bus.in_imm   = 32'd102;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_in_ready", 64'(bus.in_ready), 64'd0);
         check("stall_out_result", 64'(bus.out_result), 64'd100);
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      issue(OP_ADD, 0, 0, 7, 32'd102, 1'b1, 1'b1, t0);
      drain();
      check("stall_retire_count", 64'(log_q.size()), 64'(n0 + 3));
      check_log("stall_order0", n0, 32'd100, 4'b0000);
      check_log("stall_order1", n0 + 1, 32'd101, 4'b0000);
      check_log("stall_order2", n0 + 2, 32'd102, 4'b0000);

      // Reset with both stages full; nothing retires and r1 reads back cleared.
      bus.out_ready = 1'b0;
      issue(OP_ADD, 0, 0, 1, 32'd77, 1'b1, 1'b1, t0);
      issue(OP_ADD, 0, 0, 2, 32'd78, 1'b1, 1'b1, t0);
      n0 = log_q.size();
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      rel = cyc;
      issue(OP_ADD, 1, 0, 8, 32'd0, 1'b1, 1'b1, t0);
      check("first_accept_after_rst", 64'(t0), 64'(rel));
      check("midrst_no_retire", 64'(log_q.size()), 64'(n0));
      drain();
      check_log("midrst_reg_cleared", n0, 32'd0, 4'b0100);

      // Randomized traffic with one reset pulse in the middle.
      for (int k = 0; k < 1500; k++) begin
         if (k == 700) rst_n = 1'b0;
         if (k == 703) rst_n = 1'b1;
         bus.in_valid   = ($urandom_range(0, 9) < 7);
         bus.in_op      = 4'($urandom_range(0, 15));
         bus.in_rs1     = 5'($urandom_range(0, 7));
         bus.in_rs2     = 5'($urandom_range(0, 7));
         bus.in_rd      = 5'($urandom_range(0, 7));
         case ($urandom_range(0, 3))
            0:       bus.in_imm = $urandom;
            1:       bus.in_imm = 32'($urandom_range(0, 40));
            default: bus.in_imm = edge_vals[$urandom_range(0, 4)];
         endcase
         bus.in_use_imm = 1'($urandom_range(0, 1));
         bus.in_wr_en   = ($urandom_range(0, 3) != 0);
         bus.out_ready  = ($urandom_range(0, 9) < 7);
         @(posedge clk);
         #1;
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
